// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings and the W-stage register layout.
package mips_pkg;

    localparam int LOAD_TYPE_W = 3;

    typedef enum logic [LOAD_TYPE_W-1:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_type_e;

    typedef struct packed {
        logic                   valid;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic [LOAD_TYPE_W-1:0] load_type;
        logic [4:0]             write_reg;
        logic [31:0]            alu_out;
        logic [31:0]            read_data;
    } w_reg_t;

endpackage

// File: rtl/load_align.sv
// Big-endian sub-word load extraction with sign/zero extension and misalignment detection.
module load_align
    import mips_pkg::*;
(
    input  logic                   mem_to_reg,
    input  logic [LOAD_TYPE_W-1:0] load_type,
    input  logic [1:0]             addr,
    input  logic [31:0]            read_data,
    output logic [31:0]            load_data,
    output logic                   misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        misalign_raw;

    // Byte 0 is the most significant byte of the word.
    always_comb begin
        case (addr)
            2'b00:   byte_sel = read_data[31:24];
            2'b01:   byte_sel = read_data[23:16];
            2'b10:   byte_sel = read_data[15:8];
            default: byte_sel = read_data[7:0];
        endcase
        half_sel = addr[1] ? read_data[15:0] : read_data[31:16];
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        load_data    = read_data;
        misalign_raw = 1'b0;
        case (load_type)
            LT_LW:  misalign_raw = (addr != 2'b00);
            LT_LH: begin
                load_data    = {{16{half_sel[15]}}, half_sel};
                misalign_raw = addr[0];
            end
            LT_LHU: begin
                load_data    = {16'h0000, half_sel};
                misalign_raw = addr[0];
            end
            LT_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: load_data = {24'h000000, byte_sel};
            default: misalign_raw = 1'b1;
        endcase
    end

    assign misalign = mem_to_reg & misalign_raw;

endmodule

// File: rtl/wb_stage.sv
// Write-back pipeline stage: W register, register-file write port and retired-instruction counter.
module wb_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall_W,
    input  logic                   flush_W,
    input  logic                   valid_M,
    input  logic                   reg_write_M,
    input  logic                   mem_to_reg_M,
    input  logic [LOAD_TYPE_W-1:0] load_type_M,
    input  logic [4:0]             write_reg_M,
    input  logic [31:0]            alu_out_M,
    input  logic [31:0]            read_data_M,
    output logic                   rw,
    output logic [4:0]             write_add,
    output logic [31:0]            data_in,
    output logic                   valid_W,
    output logic                   misalign_W,
    output logic [CNT_W-1:0]       retire_count
);

    w_reg_t      w_q;
    logic [31:0] load_data;
    logic        retire;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // A flush loads an all-zero bubble, which also clears misalign via mem_to_reg.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q <= '0;
        end else if (flush_W) begin
            w_q <= '0;
        end else if (!stall_W) begin
            w_q <= '{valid:      valid_M,
                     reg_write:  reg_write_M,
                     mem_to_reg: mem_to_reg_M,
                     load_type:  load_type_M,
                     write_reg:  write_reg_M,
                     alu_out:    alu_out_M,
                     read_data:  read_data_M};
        end
    end

    // The outgoing instruction retires whenever the slot is replaced, including by a flush.
    assign retire = w_q.valid & (flush_W | ~stall_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (retire) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    load_align u_load_align (
        .mem_to_reg (w_q.mem_to_reg),
        .load_type  (w_q.load_type),
        .addr       (w_q.alu_out[1:0]),
        .read_data  (w_q.read_data),
        .load_data  (load_data),
        .misalign   (misalign_W)
    );

    assign valid_W   = w_q.valid;
    assign write_add = w_q.write_reg;
    assign data_in   = w_q.mem_to_reg ? load_data : w_q.alu_out;
    assign rw        = w_q.valid & w_q.reg_write & (w_q.write_reg != 5'd0) & ~misalign_W;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a slot-level model.
module tb_wb_stage;
    import mips_pkg::*;

    localparam int CNT_W = 4;
    localparam int OUT_W = 8 + 32 + CNT_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall_W, flush_W;
    logic              valid_M, reg_write_M, mem_to_reg_M;
    logic [2:0]        load_type_M;
    logic [4:0]        write_reg_M;
    logic [31:0]       alu_out_M, read_data_M;
    logic              rw;
    logic [4:0]        write_add;
    logic [31:0]       data_in;
    logic              valid_W, misalign_W;
    logic [CNT_W-1:0]  retire_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents of the W slot and the retired total.
    logic        s_valid, s_regw, s_mtr;
    logic [2:0]  s_lt;
    logic [4:0]  s_wr;
    logic [31:0] s_alu, s_rd;
    int unsigned m_cnt;

    wb_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_W      (stall_W),
        .flush_W      (flush_W),
        .valid_M      (valid_M),
        .reg_write_M  (reg_write_M),
        .mem_to_reg_M (mem_to_reg_M),
        .load_type_M  (load_type_M),
        .write_reg_M  (write_reg_M),
        .alu_out_M    (alu_out_M),
        .read_data_M  (read_data_M),
        .rw           (rw),
        .write_add    (write_add),
        .data_in      (data_in),
        .valid_W      (valid_W),
        .misalign_W   (misalign_W),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [OUT_W-1:0] dut_out();
        return {valid_W, misalign_W, rw, write_add, data_in, retire_count};
    endfunction

    function automatic logic exp_mis();
        int a = int'(s_alu[1:0]);
        if (!s_mtr) return 1'b0;
        if (s_lt > 3'd4) return 1'b1;
        if (s_lt == 3'd0 && a != 0) return 1'b1;
        if ((s_lt == 3'd1 || s_lt == 3'd2) && (a % 2) == 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_data();
        int a = int'(s_alu[1:0]);
        logic [31:0] b, h;
        if (!s_mtr) return s_alu;
        b = (s_rd >> (24 - 8 * a)) & 32'hFF;
        h = (s_rd >> ((a >= 2) ? 0 : 16)) & 32'hFFFF;
        case (s_lt)
            3'd0:    return s_rd;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            default: return s_rd;
        endcase
    endfunction

    function automatic logic [OUT_W-1:0] expect_out();
        logic e_rw = s_valid && s_regw && (s_wr != 5'd0) && !exp_mis();
        return {s_valid, exp_mis(), e_rw, s_wr, exp_data(), CNT_W'(m_cnt)};
    endfunction

    // Address/data of an empty slot and data of a reserved load are not defined, so they are not compared.
    function automatic logic [OUT_W-1:0] expect_mask();
        logic [4:0]  wa_m = s_valid ? 5'h1F : 5'h00;
        logic [31:0] d_m  = (s_valid && !(s_mtr && s_lt > 3'd4)) ? 32'hFFFF_FFFF : 32'h0;
        return {3'b111, wa_m, d_m, {CNT_W{1'b1}}};
    endfunction

    task automatic model_reset();
        s_valid = 1'b0; s_regw = 1'b0; s_mtr = 1'b0; s_lt = 3'd0;
        s_wr = 5'd0; s_alu = 32'd0; s_rd = 32'd0; m_cnt = 0;
    endtask

    task automatic set_m(input logic v, input logic rwr, input logic mtr, input logic [2:0] lt,
                         input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd);
        valid_M = v; reg_write_M = rwr; mem_to_reg_M = mtr; load_type_M = lt;
        write_reg_M = wr; alu_out_M = alu; read_data_M = rd;
    endtask

    task automatic rand_m();
        logic [2:0] lt;
        lt = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        set_m($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              lt, 5'($urandom), $urandom, $urandom);
    endtask

    // One clock edge; the model applies the slot-replacement rules at the same edge.
    task automatic tick();
        @(posedge clk);
        if (s_valid && (flush_W || !stall_W)) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (flush_W) begin
            s_valid = 1'b0; s_regw = 1'b0; s_mtr = 1'b0;
        end else if (!stall_W) begin
            s_valid = valid_M; s_regw = reg_write_M; s_mtr = mem_to_reg_M; s_lt = load_type_M;
            s_wr = write_reg_M; s_alu = alu_out_M; s_rd = read_data_M;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] got;
        reset = 1'b1; stall_W = 1'b0; flush_W = 1'b0;
        rand_m();
        model_reset();
        #1;
        got = dut_out(); checks++;
        if (got !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", got); end
        @(posedge clk); #1;
        got = dut_out(); checks++;
        if (got !== '0) begin failures++; $display("FAIL reset_held_edge got=%h exp=0", got); end
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd9, 32'h1234_5678, 32'h0);
        reset = 1'b0;
        tick();
        got = dut_out(); checks++;
        if (((got ^ expect_out()) & expect_mask()) !== '0) begin
            failures++; $display("FAIL first_capture got=%h exp=%h", got, expect_out());
        end
    endtask

    task automatic test_loads();
        logic [OUT_W-1:0] got;
        int unsigned saved;
        logic [31:0] lit [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8001, 32'h0};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_m(1'b1, 1'b1, 1'b1, LT_LB,  5'd7, 32'h0000_1001, 32'h80FF_1234);
                1: set_m(1'b1, 1'b1, 1'b1, LT_LBU, 5'd7, 32'h0000_1001, 32'h80FF_1234);
                2: set_m(1'b1, 1'b1, 1'b1, LT_LH,  5'd3, 32'h0000_2002, 32'h0000_8001);
                default: set_m(1'b1, 1'b1, 1'b1, LT_LH, 5'd3, 32'h0000_2001, 32'h0000_8001);
            endcase
            tick();
            got = dut_out(); checks++;
            if (((got ^ expect_out()) & expect_mask()) !== '0) begin
                failures++; $display("FAIL load_model_%0d got=%h exp=%h", i, got, expect_out());
            end
            checks++;
            if (i < 3 && (data_in !== lit[i] || rw !== 1'b1 || misalign_W !== 1'b0)) begin
                failures++;
                $display("FAIL load_lit_%0d data_in=%h rw=%b mis=%b exp data_in=%h rw=1 mis=0",
                         i, data_in, rw, misalign_W, lit[i]);
            end else if (i == 3 && (misalign_W !== 1'b1 || rw !== 1'b0)) begin
                failures++; $display("FAIL lh_misalign mis=%b rw=%b exp mis=1 rw=0", misalign_W, rw);
            end
        end
        saved = m_cnt;
        set_m(1'b0, 1'b0, 1'b0, LT_LW, 5'd0, 32'h0, 32'h0);
        tick();
        checks++;
        if (retire_count !== CNT_W'(saved + 1)) begin
            failures++; $display("FAIL misalign_retired got=%0d exp=%0d", retire_count, CNT_W'(saved + 1));
        end
    endtask

    task automatic test_alu();
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd0, 32'hDEAD_BEEF, 32'h0);
        tick();
        checks++;
        if (rw !== 1'b0) begin failures++; $display("FAIL alu_r0_rw got=%b exp=0", rw); end
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd5, 32'hDEAD_BEEF, 32'h1111_2222);
        tick();
        checks++;
        if (rw !== 1'b1 || write_add !== 5'd5 || data_in !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL alu_r5 rw=%b wa=%0d data=%h exp rw=1 wa=5 data=deadbeef", rw, write_add, data_in);
        end
    endtask

    task automatic test_stall_flush();
        logic [OUT_W-1:0] got;
        int unsigned saved;
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd12, 32'hCAFE_0001, 32'h0);
        tick();
        saved = m_cnt;
        stall_W = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_m();
            tick();
            got = dut_out(); checks++;
            if (((got ^ expect_out()) & expect_mask()) !== '0 || write_add !== 5'd12 ||
                data_in !== 32'hCAFE_0001 || retire_count !== CNT_W'(saved)) begin
                failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, got, expect_out());
            end
        end
        flush_W = 1'b1;
        tick();
        checks++;
        if (valid_W !== 1'b0 || rw !== 1'b0 || misalign_W !== 1'b0 || retire_count !== CNT_W'(saved + 1)) begin
            failures++;
            $display("FAIL stall_flush valid=%b rw=%b mis=%b cnt=%0d exp valid=0 rw=0 mis=0 cnt=%0d",
                     valid_W, rw, misalign_W, retire_count, CNT_W'(saved + 1));
        end
        stall_W = 1'b0; flush_W = 1'b0;
    endtask

    task automatic test_wrap();
        reset = 1'b1; #2; reset = 1'b0;
        model_reset();
        set_m(1'b1, 1'b0, 1'b0, LT_LW, 5'd1, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (retire_count !== 4'd15) begin failures++; $display("FAIL wrap_preload got=%0d exp=15", retire_count); end
        tick();
        checks++;
        if (retire_count !== 4'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", retire_count); end
    endtask

    task automatic test_async_reset();
        logic [OUT_W-1:0] got;
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd20, 32'h0BAD_F00D, 32'h0);
        tick();
        checks++;
        if (valid_W !== 1'b1 || rw !== 1'b1) begin
            failures++; $display("FAIL async_pre valid=%b rw=%b exp 1 1", valid_W, rw);
        end
        stall_W = 1'b1;
        #2; reset = 1'b1; #1;
        got = dut_out(); checks++;
        if (got !== '0) begin failures++; $display("FAIL async_immediate got=%h exp=0", got); end
        #1; reset = 1'b0; model_reset(); #1;
        got = dut_out(); checks++;
        if (got !== '0 || rw !== 1'b0) begin failures++; $display("FAIL async_no_write got=%h exp=0", got); end
        stall_W = 1'b0;
        set_m(1'b1, 1'b1, 1'b0, LT_LW, 5'd21, 32'h0000_0042, 32'h0);
        tick();
        got = dut_out(); checks++;
        if (((got ^ expect_out()) & expect_mask()) !== '0) begin
            failures++; $display("FAIL async_recapture got=%h exp=%h", got, expect_out());
        end
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] got;
        for (int i = 0; i < 300; i++) begin
            rand_m();
            stall_W = ($urandom_range(0, 4) == 0);
            flush_W = ($urandom_range(0, 7) == 0);
            tick();
            got = dut_out(); checks++;
            if (((got ^ expect_out()) & expect_mask()) !== '0) begin
                failures++; $display("FAIL random_%0d got=%h exp=%h", i, got, expect_out());
            end
        end
        stall_W = 1'b0; flush_W = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_alu();
        test_stall_flush();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall_W  input  1  hold the W register contents this cycle.
REQ-005 flush_W  input  1  load a bubble into the W register this cycle.
REQ-006 valid_M  input  1  M-stage slot holds a real instruction.
REQ-007 reg_write_M  input  1  instruction writes the register file.
REQ-008 mem_to_reg_M  input  1  result comes from memory (1) or the ALU (0).
REQ-009 load_type_M  input  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; others are reserved.
REQ-010 write_reg_M  input  5  destination register number.
REQ-011 alu_out_M  input  32  ALU result or effective address.
REQ-012 read_data_M  input  32  raw aligned memory word.
REQ-013 rw  output  1  register-file write enable to the decode stage.
REQ-014 write_add  output  5  register-file write address.
REQ-015 data_in  output  32  register-file write data.
REQ-016 valid_W  output  1  W slot holds a real instruction.
REQ-017 misalign_W  output  1  W instruction is a misaligned load.
REQ-018 retire_count  output  CNT_W  count of retired instructions.

Function
REQ-019 The W register SHALL capture all M inputs on each rising clk edge when stall_W=0 and flush_W=0, giving a latency of one cycle from M to the outputs.
REQ-020 flush_W=1 SHALL clear valid, reg_write, and misalign in the W register; flush_W SHALL take priority over stall_W when both are high.
REQ-021 stall_W=1 with flush_W=0 SHALL leave the W register unchanged.
REQ-022 rw SHALL equal valid_W AND reg_write_W AND (write_add≠0) AND NOT misalign_W.
REQ-023 data_in SHALL equal alu_out_W when mem_to_reg_W=0; otherwise it SHALL equal the extracted load value.
REQ-024 Load extraction SHALL be big-endian using the registered addr[1:0]: byte k = read_data[31-8k : 24-8k], and halfword h = addr[1] ? bits 15:0 : bits 31:16.
REQ-025 lb and lh SHALL sign-extend; lbu and lhu SHALL zero-extend; lw SHALL pass the word unchanged.
REQ-026 misalign_W SHALL be 1 for lh/lhu with addr[0]=1, for lw with addr[1:0]≠0, and for reserved load_type values, whenever mem_to_reg_W=1.
REQ-027 retire_count SHALL increment by 1 on every edge where valid_W=1 and the W register is being replaced (stall_W=0).
REQ-028 A flush edge SHALL still count an outgoing valid instruction.
REQ-029 retire_count SHALL wrap from all-ones to 0 without saturation.
REQ-030 Misaligned and rw-suppressed instructions SHALL still be counted as retired.
REQ-031 The register file SHALL observe rw, write_add, and data_in combinationally from the W register; the RF write happens on the following clk edge.

Reset
REQ-032 While reset=1, the W register, misalign_W, valid_W, rw, write_add, data_in, and retire_count SHALL all be 0, asynchronously.
REQ-033 Reset asserted mid-stall SHALL discard the held instruction with no RF write.
REQ-034 The first edge after reset deassertion SHALL capture the M inputs normally.

Structure
REQ-035 The load_type encodings and the LOAD_TYPE_W constant SHALL reside in the shared package mips_pkg.
REQ-036 Load extraction and misalignment detection SHALL be one combinational sub-module, load_align.
REQ-037 The W register and the counter SHALL reside in wb_stage.

Verification
REQ-038 lb: read_data=0x80FF_1234, addr=0x...01 -> data_in=0xFFFF_FFFF one cycle later; lbu with the same inputs -> 0x0000_00FF.
REQ-039 lh with addr[1:0]=10 and read_data=0x0000_8001 -> data_in=0xFFFF_8001, rw=1; lh with addr[1:0]=01 -> misalign_W=1, rw=0, retire_count still increments.
REQ-040 ALU write to r0 (write_reg=0, reg_write=1) -> rw=0; the same write to r5 with alu_out=0xDEAD_BEEF -> rw=1, write_add=5, data_in=0xDEAD_BEEF.
REQ-041 stall_W high for 3 cycles, then flush_W and stall_W high together -> outputs hold for 3 cycles, the next edge gives valid_W=0, and retire_count rises by exactly 1.
REQ-042 retire_count preloaded via 2^CNT_W−1 valid retires (CNT_W=4: 15 retires) -> the 16th retire gives retire_count=0.
REQ-043 reset pulsed asynchronously between edges while valid_W=1 -> all outputs read 0 immediately, with no RF write on the next edge.
